// File: rtl/game_pkg.sv
// Shared screen geometry for the sky, catcher, score and mouse blocks,
// plus the catcher position helpers used by the mouse tracker.
package game_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int CATCHER_W = 16;
  localparam int CATCHER_Y = 104;

  localparam int POS_W  = 8;
  localparam int CAND_W = 11;

  // Fields of a PS/2 mouse packet that the tracker actually consumes.
  typedef struct packed {
    logic       x_ovf;
    logic       x_sign;
    logic [2:0] btn;
    logic [7:0] dx_low;
  } mouse_pkt_t;

  function automatic logic [POS_W-1:0] clamp_x(
    input logic signed [CAND_W-1:0] cand,
    input logic signed [CAND_W-1:0] max_x
  );
    if (cand < 11'sd0)
      return '0;
    if (cand > max_x)
      return max_x[POS_W-1:0];
    return cand[POS_W-1:0];
  endfunction

endpackage

// File: rtl/mouse_tracker.sv
// Parses 3-byte PS/2 mouse packets and turns the X delta into a clamped
// catcher position; partial packets are dropped after an idle timeout.
module mouse_tracker #(
  parameter int SCREEN_W  = game_pkg::SCREEN_W,
  parameter int CATCHER_W = game_pkg::CATCHER_W,
  parameter int START_X   = 72,
  parameter int SHIFT     = 1,
  parameter int TIMEOUT   = 1048576
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] position,
  output logic [2:0] buttons,
  output logic       packet_done,
  output logic       sync_error
);
  import game_pkg::*;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [CAND_W-1:0] MAX_X = CAND_W'(SCREEN_W - CATCHER_W);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  state_t           state, state_nxt;
  mouse_pkt_t       pkt;
  logic [CNT_W-1:0] idle_cnt;

  logic expired;
  logic load_b0, load_b1, complete, drop, cnt_run;

  logic signed [8:0]        dx;
  logic signed [8:0]        dx_scaled;
  logic signed [CAND_W-1:0] cand;
  logic [POS_W-1:0]         pos_new;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expired = (state != WAIT_B0) && !rx_valid && (idle_cnt == TO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT_B0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_B0: if (rx_valid && rx_data[3]) state_nxt = WAIT_B1;
      WAIT_B1: begin
        if (rx_valid)     state_nxt = WAIT_B2;
        else if (expired) state_nxt = WAIT_B0;
      end
      WAIT_B2: if (rx_valid || expired) state_nxt = WAIT_B0;
      default: state_nxt = WAIT_B0;
    endcase
  end

  always_comb begin
    load_b0  = 1'b0;
    load_b1  = 1'b0;
    complete = 1'b0;
    drop     = expired;
    cnt_run  = (state != WAIT_B0) && !rx_valid && !expired;
    case (state)
      WAIT_B0: begin
        load_b0 = rx_valid && rx_data[3];
        drop    = rx_valid && !rx_data[3];
      end
      WAIT_B1: load_b1  = rx_valid;
      WAIT_B2: complete = rx_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        idle_cnt <= '0;
    else if (cnt_run) idle_cnt <= idle_cnt + 1'b1;
    else              idle_cnt <= '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt <= '0;
    end else begin
      if (load_b0) begin
        pkt.x_ovf  <= rx_data[6];
        pkt.x_sign <= rx_data[4];
        pkt.btn    <= rx_data[2:0];
      end
      if (load_b1)
        pkt.dx_low <= rx_data;
    end
  end

  assign dx        = $signed({pkt.x_sign, pkt.dx_low});
  assign dx_scaled = dx >>> SHIFT;
  assign cand      = $signed({3'b000, position}) + {{2{dx_scaled[8]}}, dx_scaled};
  assign pos_new   = clamp_x(cand, MAX_X);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      position    <= 8'(START_X);
      buttons     <= '0;
      packet_done <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      packet_done <= complete;
      sync_error  <= drop;
      if (complete) begin
        buttons <= pkt.btn;
        // An overflowed delta is meaningless, so only the buttons are taken.
        if (enable && !pkt.x_ovf)
          position <= pos_new;
      end
    end
  end

endmodule
